// File: rtl/stack_mem_access_pkg.sv
// -----------------------------------------------------------------------------
// stack_mem_access_pkg
// Shared definitions for the stack datapath: stack-op encodings (also used by
// the SP control stage), fault codes reported with done, and the FSM state
// encoding of stack_mem_access. Small helpers classify an op as a stack
// write (PUSH/CALL) or a stack read (POP/RET).
// -----------------------------------------------------------------------------
package stack_mem_access_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'b000,
        OP_PUSH = 3'b001,
        OP_POP  = 3'b010,
        OP_CALL = 3'b011,
        OP_RET  = 3'b100
    } stack_op_e;

    typedef enum logic [1:0] {
        FLT_NONE      = 2'b00,
        FLT_OVERFLOW  = 2'b01,
        FLT_UNDERFLOW = 2'b10,
        FLT_TIMEOUT   = 2'b11
    } fault_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_FIN  = 2'd2
    } state_e;

    function automatic logic is_write_op(input logic [2:0] op);
        return (op == OP_PUSH) || (op == OP_CALL);
    endfunction

    function automatic logic is_read_op(input logic [2:0] op);
        return (op == OP_POP) || (op == OP_RET);
    endfunction

endpackage

// File: rtl/stack_mem_access_bounds.sv
// -----------------------------------------------------------------------------
// stack_bounds_chk
// Combinational stack-region check for one op/address pair.
//   op    : stack op (3-bit encoding from stack_mem_access_pkg)
//   addr  : stack word address, compared unsigned
//   fault : FLT_OVERFLOW when a write goes below STACK_LO,
//           FLT_UNDERFLOW when a read goes above STACK_HI, else FLT_NONE.
// NOP and unknown ops never fault.
// -----------------------------------------------------------------------------
module stack_bounds_chk
    import stack_mem_access_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] STACK_LO = 32'h0000_0300,
    parameter logic [ADDR_W-1:0] STACK_HI = 32'h0000_03FF
) (
    input  logic [2:0]        op,
    input  logic [ADDR_W-1:0] addr,
    output logic [1:0]        fault
);

    // The stack grows downward: writes can only run off the bottom, reads
    // can only run off the top.
    always_comb begin
        fault = FLT_NONE;
        if (is_write_op(op) && (addr < STACK_LO)) begin
            fault = FLT_OVERFLOW;
        end else if (is_read_op(op) && (addr > STACK_HI)) begin
            fault = FLT_UNDERFLOW;
        end
    end

endmodule

// File: rtl/stack_mem_access.sv
// -----------------------------------------------------------------------------
// stack_mem_access
// Performs the single data-memory access of PUSH/POP/CALL/RET after the SP
// control stage has produced the stack address. The address is bounds-checked
// first; an out-of-range or NOP op completes without touching memory.
//
// Ports:
//   clk, rst             clock; synchronous active-low reset
//   start, stack_op      one-cycle request, sampled only in IDLE
//   mem_sp               stack word address for the access
//   rs_data, npc         store data for PUSH / CALL
//   busy, done           busy while the memory access is outstanding;
//                        done pulses for one cycle at completion
//   lmd, ret_pc          POP load data / RET target, held until replaced
//   fault                00 none, 01 overflow, 10 underflow, 11 timeout;
//                        valid with done, cleared by the next accepted start
//   mem_req/we/addr/wdata, mem_ack/rdata   req/ack data-memory port
//
// Build option: define STACK_TIMEOUT_EN to enable the ack watchdog; after
// TIMEOUT_CYC request cycles without mem_ack the access is abandoned with
// fault 11. Without it, REQ waits for mem_ack indefinitely.
// -----------------------------------------------------------------------------
module stack_mem_access
    import stack_mem_access_pkg::*;
#(
    parameter int                ADDR_W      = 32,
    parameter int                DATA_W      = 32,
    parameter logic [ADDR_W-1:0] STACK_LO    = 32'h0000_0300,
    parameter logic [ADDR_W-1:0] STACK_HI    = 32'h0000_03FF,
    parameter int                TIMEOUT_CYC = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [2:0]        stack_op,
    input  logic [ADDR_W-1:0] mem_sp,
    input  logic [DATA_W-1:0] rs_data,
    input  logic [DATA_W-1:0] npc,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] lmd,
    output logic [DATA_W-1:0] ret_pc,
    output logic [1:0]        fault,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e     state;
    logic [2:0] op_q;
    logic [1:0] chk_fault;
    logic       legal_mem_op;

    // Checking the incoming address at the accepting edge is the same as
    // checking the latched copy, and lets a faulting op finish one cycle
    // after start.
    stack_bounds_chk #(
        .ADDR_W   (ADDR_W),
        .STACK_LO (STACK_LO),
        .STACK_HI (STACK_HI)
    ) u_bounds (
        .op    (stack_op),
        .addr  (mem_sp),
        .fault (chk_fault)
    );

    assign legal_mem_op = (chk_fault == FLT_NONE) &&
                          (is_write_op(stack_op) || is_read_op(stack_op));

`ifdef STACK_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] wd_cnt;
`else
    // TIMEOUT_CYC only matters when the watchdog is built in.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = |TIMEOUT_CYC;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= ST_IDLE;
            op_q      <= OP_NOP;
            busy      <= 1'b0;
            done      <= 1'b0;
            lmd       <= '0;
            ret_pc    <= '0;
            fault     <= FLT_NONE;
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
`ifdef STACK_TIMEOUT_EN
            wd_cnt    <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q  <= stack_op;
                        fault <= chk_fault;
                        if (legal_mem_op) begin
                            state    <= ST_REQ;
                            busy     <= 1'b1;
                            mem_req  <= 1'b1;
                            mem_we   <= is_write_op(stack_op);
                            mem_addr <= mem_sp;
                            if (is_write_op(stack_op)) begin
                                mem_wdata <= (stack_op == OP_CALL) ? npc : rs_data;
                            end
`ifdef STACK_TIMEOUT_EN
                            wd_cnt   <= '0;
`endif
                        end else begin
                            // Fault or NOP: complete without a memory cycle.
                            state <= ST_FIN;
                            done  <= 1'b1;
                        end
                    end
                end

                ST_REQ: begin
                    if (mem_ack) begin
                        if (op_q == OP_POP) begin
                            lmd <= mem_rdata;
                        end
                        if (op_q == OP_RET) begin
                            ret_pc <= mem_rdata;
                        end
                        mem_req <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= ST_FIN;
                    end
`ifdef STACK_TIMEOUT_EN
                    else if (wd_cnt == CNT_W'(TIMEOUT_CYC - 1)) begin
                        // Abandon the access; load registers keep old values.
                        mem_req <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        fault   <= FLT_TIMEOUT;
                        state   <= ST_FIN;
                    end else begin
                        wd_cnt <= wd_cnt + 1'b1;
                    end
`endif
                end

                // start arriving in the done cycle is dropped here.
                ST_FIN: begin
                    state <= ST_IDLE;
                end

                default: begin
                    state   <= ST_IDLE;
                    busy    <= 1'b0;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_mem_access.sv
// -----------------------------------------------------------------------------
// tb_stack_mem_access
// Self-checking bench for stack_mem_access: a directed vector table, randomized
// operations checked against a word-addressed memory model with the stack
// bound rules, and hand-written reset / no-ack sequences.
// -----------------------------------------------------------------------------
module tb_stack_mem_access;

    localparam logic [31:0] LO = 32'h0000_0300;
    localparam logic [31:0] HI = 32'h0000_03FF;
    localparam logic [2:0] P_NOP  = 3'd0;
    localparam logic [2:0] P_PUSH = 3'd1;
    localparam logic [2:0] P_POP  = 3'd2;
    localparam logic [2:0] P_CALL = 3'd3;
    localparam logic [2:0] P_RET  = 3'd4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  stack_op;
    logic [31:0] mem_sp;
    logic [31:0] rs_data;
    logic [31:0] npc;
    logic        busy;
    logic        done;
    logic [31:0] lmd;
    logic [31:0] ret_pc;
    logic [1:0]  fault;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int checks = 0;
    int errors = 0;

    // Reference state: expected held load results and stack memory contents.
    logic [31:0] lmd_m = '0;
    logic [31:0] ret_pc_m = '0;
    logic [31:0] mem_model [logic [31:0]];

    always #5 clk = ~clk;

    stack_mem_access dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .stack_op  (stack_op),
        .mem_sp    (mem_sp),
        .rs_data   (rs_data),
        .npc       (npc),
        .busy      (busy),
        .done      (done),
        .lmd       (lmd),
        .ret_pc    (ret_pc),
        .fault     (fault),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata)
    );

    typedef struct {
        logic [2:0]  op;
        logic [31:0] sp;
        logic [31:0] wd;
        logic [31:0] nv;
        int          waitc;
        logic [31:0] rdata;
        logic [1:0]  exp_fault;
        logic [31:0] exp_data;
    } vec_t;

    vec_t vecs[15];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic is_wr(input logic [2:0] op);
        return (op == P_PUSH) || (op == P_CALL);
    endfunction

    function automatic logic is_rd(input logic [2:0] op);
        return (op == P_POP) || (op == P_RET);
    endfunction

    // Stack rules: writes may not go below LO, reads may not go above HI.
    function automatic logic [1:0] model_fault(input logic [2:0] op, input logic [31:0] sp);
        if (is_wr(op) && sp < LO) return 2'b01;
        if (is_rd(op) && sp > HI) return 2'b10;
        return 2'b00;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Called at #1 after an edge; that cycle is cycle 0 of the operation.
    task automatic do_op(input string tag, input logic [2:0] op, input logic [31:0] sp,
                         input logic [31:0] wd, input logic [31:0] nv, input int waitc,
                         input logic [31:0] rdata, input logic [1:0] exp_fault,
                         input logic [31:0] exp_data);
        logic legal;
        logic [31:0] exp_wd;
        legal  = (exp_fault == 2'b00) && (is_wr(op) || is_rd(op));
        exp_wd = (op == P_CALL) ? nv : wd;
        start = 1'b1; stack_op = op; mem_sp = sp; rs_data = wd; npc = nv; mem_ack = 1'b0;
        step();
        // Scramble inputs so only latched values can appear on the memory port.
        start = 1'b0; stack_op = 3'($urandom); mem_sp = $urandom; rs_data = $urandom; npc = $urandom;
        if (legal) begin
            chk({tag, " req@1"}, {mem_req, busy, done}, 3'b110);
            chk({tag, " mem_we"}, mem_we, is_wr(op));
            chk({tag, " mem_addr"}, mem_addr, sp);
            if (is_wr(op)) chk({tag, " mem_wdata"}, mem_wdata, exp_wd);
            for (int c = 1; c <= 1 + waitc; c++) begin
                if (c > 1) chk({tag, " wait req/busy/done"}, {mem_req, busy, done}, 3'b110);
                start = 1'($urandom_range(0, 1));
                if (c == 1 + waitc) begin
                    mem_ack = 1'b1;
                    mem_rdata = rdata;
                end
                step();
                mem_ack = 1'b0;
            end
            start = 1'b0;
        end
        chk({tag, " done"}, {done, busy, mem_req}, 3'b100);
        chk({tag, " fault"}, fault, exp_fault);
        if (legal && op == P_POP) lmd_m = exp_data;
        if (legal && op == P_RET) ret_pc_m = exp_data;
        if (legal && is_wr(op)) mem_model[sp] = exp_wd;
        chk({tag, " lmd"}, lmd, lmd_m);
        chk({tag, " ret_pc"}, ret_pc, ret_pc_m);
        // start and ack in the done cycle must both be ignored.
        start = 1'b1; stack_op = P_POP; mem_sp = 32'h3F0; mem_ack = 1'b1; mem_rdata = $urandom;
        step();
        start = 1'b0; mem_ack = 1'b0;
        chk({tag, " after done"}, {done, busy, mem_req}, 3'b000);
        chk({tag, " fault hold"}, fault, exp_fault);
        chk({tag, " lmd hold"}, lmd, lmd_m);
        chk({tag, " ret_pc hold"}, ret_pc, ret_pc_m);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: time limit reached, checks %0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0]  op;
        logic [31:0] sp, wd, nv, rd;
        logic [1:0]  f;
        int          w;

        vecs[0]  = '{P_PUSH, 32'h3FE, 32'hDEADBEEF, 32'h0,  0, 32'h0,        2'b00, 32'h0};
        vecs[1]  = '{P_POP,  32'h3FE, 32'h0,        32'h0,  3, 32'h1234,     2'b00, 32'h1234};
        vecs[2]  = '{P_CALL, 32'h3FD, 32'h5555,     32'h40, 1, 32'h0,        2'b00, 32'h0};
        vecs[3]  = '{P_RET,  32'h3FD, 32'h0,        32'h0,  0, 32'h40,       2'b00, 32'h40};
        vecs[4]  = '{P_PUSH, 32'h2FF, 32'h11111111, 32'h0,  0, 32'h0,        2'b01, 32'h0};
        vecs[5]  = '{P_POP,  32'h400, 32'h0,        32'h0,  0, 32'h0,        2'b10, 32'h0};
        vecs[6]  = '{P_CALL, 32'h2FF, 32'h0,        32'h77, 0, 32'h0,        2'b01, 32'h0};
        vecs[7]  = '{P_RET,  32'h400, 32'h0,        32'h0,  0, 32'h0,        2'b10, 32'h0};
        vecs[8]  = '{P_PUSH, 32'h300, 32'hA5A5A5A5, 32'h0,  2, 32'h0,        2'b00, 32'h0};
        vecs[9]  = '{P_POP,  32'h3FF, 32'h0,        32'h0,  0, 32'hCAFEF00D, 2'b00, 32'hCAFEF00D};
        vecs[10] = '{P_NOP,  32'h2FF, 32'h0,        32'h0,  0, 32'h0,        2'b00, 32'h0};
        vecs[11] = '{3'd7,   32'h0,   32'h0,        32'h0,  0, 32'h0,        2'b00, 32'h0};
        vecs[12] = '{P_POP,  32'h2FF, 32'h0,        32'h0,  1, 32'h77,       2'b00, 32'h77};
        vecs[13] = '{P_PUSH, 32'hFFFFFFFF, 32'h9, 32'h0,    0, 32'h0,        2'b00, 32'h0};
        vecs[14] = '{P_RET,  32'h300, 32'h0,        32'h0,  4, 32'h99,       2'b00, 32'h99};

        rst = 1'b0; start = 1'b0; stack_op = '0; mem_sp = '0; rs_data = '0; npc = '0;
        mem_ack = 1'b0; mem_rdata = '0;
        repeat (3) step();
        chk("reset ctrl", {busy, done, mem_req, mem_we, fault}, 6'b0);
        chk("reset lmd", lmd, 0);
        chk("reset ret_pc", ret_pc, 0);
        chk("reset mem_addr", mem_addr, 0);
        chk("reset mem_wdata", mem_wdata, 0);
        rst = 1'b1;
        step();

        for (int i = 0; i < 15; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].sp, vecs[i].wd, vecs[i].nv,
                  vecs[i].waitc, vecs[i].rdata, vecs[i].exp_fault, vecs[i].exp_data);
        end

        // Reset while a PUSH is waiting for ack.
        start = 1'b1; stack_op = P_PUSH; mem_sp = 32'h3E0; rs_data = 32'h0BAD; mem_ack = 1'b0;
        step();
        start = 1'b0;
        chk("rstmid req", {mem_req, busy}, 2'b11);
        step();
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("rstmid dropped", {mem_req, busy, done}, 3'b000);
        chk("rstmid lmd", lmd, 0);
        chk("rstmid ret_pc", ret_pc, 0);
        chk("rstmid fault", fault, 0);
        lmd_m = '0; ret_pc_m = '0;
        mem_ack = 1'b1; mem_rdata = 32'h5A5A;
        step();
        mem_ack = 1'b0;
        chk("late ack ignored", {done, busy, mem_req}, 3'b000);
        step();
        chk("late ack no done", {done, lmd}, 33'h0);
        do_op("post-reset pop", P_POP, 32'h310, 32'h0, 32'h0, 1, 32'h4242, 2'b00, 32'h4242);

        // Request that never receives an ack.
        start = 1'b1; stack_op = P_POP; mem_sp = 32'h3F0; mem_ack = 1'b0;
        step();
        start = 1'b0;
`ifdef STACK_TIMEOUT_EN
        for (int c = 1; c <= 16; c++) begin
            chk("noack waiting", {mem_req, busy, done}, 3'b110);
            start = 1'($urandom_range(0, 1));
            stack_op = P_PUSH; mem_sp = 32'h3A0;
            step();
        end
        start = 1'b0;
        chk("timeout done", {done, busy, mem_req}, 3'b100);
        chk("timeout fault", fault, 2'b11);
        chk("timeout lmd", lmd, lmd_m);
        step();
        chk("timeout after", {done, busy, mem_req}, 3'b000);
`else
        for (int c = 1; c <= 40; c++) begin
            chk("noack waiting", {mem_req, busy, done}, 3'b110);
            start = 1'($urandom_range(0, 1));
            stack_op = P_PUSH; mem_sp = 32'h3A0;
            step();
        end
        start = 1'b0;
        chk("noack fault", fault, 2'b00);
        rst = 1'b0;
        step();
        rst = 1'b1;
        chk("noack recover", {done, busy, mem_req}, 3'b000);
        lmd_m = '0; ret_pc_m = '0;
`endif

        // Randomized operations against the memory model.
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0) sp = $urandom;
            else sp = LO - 32'd8 + 32'($urandom_range(0, 32'h110));
            wd = $urandom;
            nv = $urandom;
            w  = $urandom_range(0, 4);
            f  = model_fault(op, sp);
            rd = mem_model.exists(sp) ? mem_model[sp] : $urandom;
            do_op($sformatf("rand%0d", i), op, sp, wd, nv, w, rd, f, rd);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
